amplitude2_sweep_unit: RTL and testbench

- Generates amplitude list 2 for a Hadamard stabilizer gate.
- Sits directly downstream of the stabilizer control unit's `determine_amplitude2` strobe and returns `done_amplitude` / `ram_amplitude_busy` to it.
- Sweeps every basis entry: reads amplitude1 from RAM ALPHA, applies the productQ2 phase (i^k) when basis_index2 matches productQ2, otherwise forces 0, and writes amplitude2 to RAM AMP2.

---
 rtl/amplitude2_sweep_unit_if.sv | 39 +++
 rtl/amplitude2_sweep_unit.sv | 148 ++++++++++++++
 tb/tb_amplitude2_sweep_unit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/amplitude2_sweep_unit_if.sv
// Control handshake and RAM ALPHA / RAM AMP2 ports of the amplitude2 sweep unit.
// slave = sweep unit side, master = stabilizer control unit / RAM side.
interface amplitude2_sweep_unit_if #(
  parameter int num_qubit = 4,
  parameter int amp_width = 16
);
  logic                 determine_amplitude2;
  logic                 phase_update_busy;
  logic [31:0]          counter_valid_vector;
  logic                 match_Q_basis_index;
  logic [1:0]           phase_Q2;
  logic                 rotateLeft_Q2_amp;
  logic                 read_ram_alpha_en;
  logic [num_qubit-1:0] read_ram_alpha_address;
  logic [amp_width-1:0] ram_alpha_real;
  logic [amp_width-1:0] ram_alpha_imag;
  logic                 write_ram_amp2_en;
  logic [num_qubit-1:0] write_ram_amp2_address;
  logic [amp_width-1:0] write_ram_amp2_real;
  logic [amp_width-1:0] write_ram_amp2_imag;
  logic                 ram_amplitude_busy;
  logic                 done_amplitude;

  modport slave (
    input  determine_amplitude2, phase_update_busy, counter_valid_vector,
           match_Q_basis_index, phase_Q2, ram_alpha_real, ram_alpha_imag,
    output rotateLeft_Q2_amp, read_ram_alpha_en, read_ram_alpha_address,
           write_ram_amp2_en, write_ram_amp2_address, write_ram_amp2_real,
           write_ram_amp2_imag, ram_amplitude_busy, done_amplitude
  );

  modport master (
    output determine_amplitude2, phase_update_busy, counter_valid_vector,
           match_Q_basis_index, phase_Q2, ram_alpha_real, ram_alpha_imag,
    input  rotateLeft_Q2_amp, read_ram_alpha_en, read_ram_alpha_address,
           write_ram_amp2_en, write_ram_amp2_address, write_ram_amp2_real,
           write_ram_amp2_imag, ram_amplitude_busy, done_amplitude
  );
endinterface

// File: rtl/amplitude2_sweep_unit.sv
// Sweeps all basis entries, applies the Q2 phase i^k to amplitude1 and writes amplitude2.
// Optional AMP2_NEG_SATURATE_EN: negating the most negative value saturates instead of wrapping.
module amplitude2_sweep_unit #(
  parameter int num_qubit  = 4,
  parameter int amp_width  = 16,
  parameter int rd_latency = 2
) (
  input logic                    clk,
  input logic                    rst,
  amplitude2_sweep_unit_if.slave bus
);
  // state   | meaning
  // S_IDLE  | waiting for determine_amplitude2
  // S_WAIT  | start accepted, holding while the beta phase update runs
  // S_SWEEP | one basis entry issued per cycle
  // S_DRAIN | waiting for the read/compute pipeline to empty
  // S_DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SWEEP, S_DRAIN, S_DONE} state_t;
  typedef logic signed [amp_width-1:0] amp_t;

  localparam amp_t AMP_MIN = {1'b1, {(amp_width-1){1'b0}}};
  localparam amp_t AMP_MAX = {1'b0, {(amp_width-1){1'b1}}};

  state_t               state_q;
  logic [num_qubit-1:0] counter_q;
  logic                 busy_q;
  logic                 done_q;

  logic [rd_latency-1:0]                vld_q;
  logic [rd_latency-1:0]                rdv_q;
  logic [rd_latency-1:0]                match_q;
  logic [rd_latency-1:0][1:0]           phase_q;
  logic [rd_latency-1:0][num_qubit-1:0] addr_q;

  logic                 wr_en_q;
  logic [num_qubit-1:0] wr_addr_q;
  amp_t                 wr_real_q;
  amp_t                 wr_imag_q;
  amp_t                 amp_real_d;
  amp_t                 amp_imag_d;
  amp_t                 re;
  amp_t                 im;
  logic                 in_sweep;
  logic                 rd_valid;

  function automatic amp_t neg(input amp_t x);
`ifdef AMP2_NEG_SATURATE_EN
    neg = (x == AMP_MIN) ? AMP_MAX : -x;
`else
    neg = -x;
`endif
  endfunction

  assign in_sweep = (state_q == S_SWEEP);
  assign rd_valid = 32'(counter_q) < bus.counter_valid_vector;
  assign re       = amp_t'(bus.ram_alpha_real);
  assign im       = amp_t'(bus.ram_alpha_imag);

  assign bus.read_ram_alpha_en      = in_sweep && rd_valid;
  assign bus.read_ram_alpha_address = in_sweep ? counter_q : '0;
  assign bus.rotateLeft_Q2_amp      = in_sweep;
  assign bus.write_ram_amp2_en      = wr_en_q;
  assign bus.write_ram_amp2_address = wr_addr_q;
  assign bus.write_ram_amp2_real    = wr_real_q;
  assign bus.write_ram_amp2_imag    = wr_imag_q;
  assign bus.ram_amplitude_busy     = busy_q;
  assign bus.done_amplitude         = done_q;

  // Last delay stage lines up with the RAM read data of the same entry.
  always_comb begin
    amp_real_d = '0;
    amp_imag_d = '0;
    if (vld_q[rd_latency-1] && rdv_q[rd_latency-1] && match_q[rd_latency-1]) begin
      case (phase_q[rd_latency-1])
        2'd0: begin amp_real_d = re;      amp_imag_d = im;      end
        2'd1: begin amp_real_d = neg(im); amp_imag_d = re;      end
        2'd2: begin amp_real_d = neg(re); amp_imag_d = neg(im); end
        default: begin amp_real_d = im;   amp_imag_d = neg(re); end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      counter_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vld_q     <= '0;
      rdv_q     <= '0;
      match_q   <= '0;
      phase_q   <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_real_q <= '0;
      wr_imag_q <= '0;
    end else begin
      done_q <= 1'b0;
      for (int i = rd_latency - 1; i > 0; i--) begin
        vld_q[i]   <= vld_q[i-1];
        rdv_q[i]   <= rdv_q[i-1];
        match_q[i] <= match_q[i-1];
        phase_q[i] <= phase_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
      vld_q[0]   <= in_sweep;
      rdv_q[0]   <= in_sweep && rd_valid;
      match_q[0] <= bus.match_Q_basis_index;
      phase_q[0] <= bus.phase_Q2;
      addr_q[0]  <= counter_q;

      wr_en_q   <= vld_q[rd_latency-1];
      wr_addr_q <= addr_q[rd_latency-1];
      wr_real_q <= amp_real_d;
      wr_imag_q <= amp_imag_d;

      case (state_q)
        S_IDLE: begin
          if (bus.determine_amplitude2) begin
            state_q <= S_WAIT;
            busy_q  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!bus.phase_update_busy) begin
            state_q   <= S_SWEEP;
            counter_q <= '0;
          end
        end
        S_SWEEP: begin
          counter_q <= counter_q + 1'b1;
          if (counter_q == '1) state_q <= S_DRAIN;
        end
        // The final write is already in the output register when the delay line empties.
        S_DRAIN: begin
          if (vld_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_amplitude2_sweep_unit.sv
// Directed bench for amplitude2_sweep_unit (num_qubit=2, amp_width=16, rd_latency=2).
module tb_amplitude2_sweep_unit;
  localparam int NQ = 2;
  localparam int AW = 16;
  localparam int RL = 2;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  int   cyc = 0;
  always #5 clk = ~clk;

  amplitude2_sweep_unit_if #(.num_qubit(NQ), .amp_width(AW)) bus ();

  amplitude2_sweep_unit #(.num_qubit(NQ), .amp_width(AW), .rd_latency(RL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [AW-1:0] ram_r [N];
  logic [AW-1:0] ram_i [N];
  logic          match_list [N];
  logic [1:0]    phase_list [N];
  logic [NQ-1:0] rd_a1, rd_a2, head;

  // RAM ALPHA with two-cycle read latency and the rotating Q2 list
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rd_a1 <= bus.read_ram_alpha_address;
    rd_a2 <= rd_a1;
    if (clr) head <= '0;
    else if (bus.rotateLeft_Q2_amp) head <= head + 1'b1;
  end
  assign bus.ram_alpha_real      = ram_r[rd_a2];
  assign bus.ram_alpha_imag      = ram_i[rd_a2];
  assign bus.match_Q_basis_index = match_list[head];
  assign bus.phase_Q2            = phase_list[head];

  int            nw, rd_count, first_sweep, first_rd, first_wr, done_cnt, done_cyc, busy_cnt;
  logic          busy_at_done;
  logic [N-1:0]  rd_mask;
  logic [NQ-1:0] wr_a [N];
  logic [AW-1:0] wr_r [N];
  logic [AW-1:0] wr_i [N];
  logic [AW-1:0] exp_r [N];
  logic [AW-1:0] exp_i [N];

  always @(negedge clk) begin
    if (clr) begin
      nw = 0; rd_count = 0; first_sweep = -1; first_rd = -1; first_wr = -1;
      done_cnt = 0; done_cyc = -1; busy_cnt = 0; busy_at_done = 1'b0; rd_mask = '0;
      for (int i = 0; i < N; i++) begin wr_a[i] = '0; wr_r[i] = '0; wr_i[i] = '0; end
    end else begin
      if (bus.read_ram_alpha_en) begin
        rd_count++;
        rd_mask[bus.read_ram_alpha_address] = 1'b1;
        if (first_rd < 0) first_rd = cyc;
      end
      if (bus.rotateLeft_Q2_amp && first_sweep < 0) first_sweep = cyc;
      if (bus.write_ram_amp2_en) begin
        if (nw < N) begin
          wr_a[nw] = bus.write_ram_amp2_address;
          wr_r[nw] = bus.write_ram_amp2_real;
          wr_i[nw] = bus.write_ram_amp2_imag;
        end
        if (nw == 0) first_wr = cyc;
        nw++;
      end
      if (bus.ram_amplitude_busy) busy_cnt++;
      if (bus.done_amplitude) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = bus.ram_amplitude_busy;
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic start_sweep(input int hold, output int p);
    p = cyc;
    bus.determine_amplitude2 = 1'b1;
    bus.phase_update_busy    = (hold > 0);
    tick();
    bus.determine_amplitude2 = 1'b0;
    repeat (hold) tick();
    bus.phase_update_busy = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == 0 && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (4) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ctl"}, 32'({bus.ram_amplitude_busy, bus.done_amplitude, bus.read_ram_alpha_en,
                            bus.rotateLeft_Q2_amp, bus.write_ram_amp2_en,
                            bus.read_ram_alpha_address, bus.write_ram_amp2_address}), 32'd0);
    chk({tag, "_data"}, {bus.write_ram_amp2_real, bus.write_ram_amp2_imag}, 32'd0);
  endtask

  // Sweep starts 2+hold cycles after the start cycle, first write 3 later,
  // done right after the 4th write; busy covers WAIT..DRAIN.
  task automatic check_timing(input string tag, input int p, input int hold);
    chk({tag, "_sweep_start"}, 32'(first_sweep), 32'(p + 2 + hold));
    chk({tag, "_first_write"}, 32'(first_wr),    32'(p + 5 + hold));
    chk({tag, "_done_cycle"},  32'(done_cyc),    32'(p + 9 + hold));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt),    32'(8 + hold));
    chk({tag, "_done_count"},  32'(done_cnt),    32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    chk({tag, "_write_count"}, 32'(nw),          32'd4);
  endtask

  task automatic check_writes(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wr_a[i]), 32'(i));
      chk($sformatf("%s_real%0d", tag, i), 32'(wr_r[i]), 32'(exp_r[i]));
      chk($sformatf("%s_imag%0d", tag, i), 32'(wr_i[i]), 32'(exp_i[i]));
    end
  endtask

  task automatic load_base();
    ram_r = '{16'd1, 16'd3, 16'd5, 16'd7};
    ram_i = '{16'd2, 16'd4, 16'd6, 16'd8};
    match_list = '{1'b1, 1'b1, 1'b1, 1'b1};
    phase_list = '{2'd0, 2'd0, 2'd0, 2'd0};
    bus.counter_valid_vector = 32'd4;
    exp_r = '{16'd1, 16'd3, 16'd5, 16'd7};
    exp_i = '{16'd2, 16'd4, 16'd6, 16'd8};
  endtask

  int p;
  int k;

  initial begin
    rst = 1'b1;
    clr = 1'b1;
    bus.determine_amplitude2 = 1'b0;
    bus.phase_update_busy    = 1'b0;
    load_base();
    repeat (3) tick();
    clr = 1'b0;
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();
    check_outputs_zero("idle");

    // phase 0, all matched: data passes through
    clear_log();
    start_sweep(0, p);
    wait_done("t1");
    check_timing("t1", p, 0);
    check_writes("t1");
    chk("t1_reads", 32'(rd_count), 32'd4);

    // phases 1,2,3,0 with valid count above the sweep length; a second start mid-sweep is ignored
    load_base();
    phase_list = '{2'd1, 2'd2, 2'd3, 2'd0};
    bus.counter_valid_vector = 32'd100;
    exp_r = '{16'hFFFE, 16'hFFFD, 16'h0006, 16'h0007};
    exp_i = '{16'h0001, 16'hFFFC, 16'hFFFB, 16'h0008};
    clear_log();
    start_sweep(0, p);
    tick();
    bus.determine_amplitude2 = 1'b1;
    tick();
    bus.determine_amplitude2 = 1'b0;
    wait_done("t2");
    check_timing("t2", p, 0);
    check_writes("t2");
    chk("t2_reads", 32'(rd_count), 32'd4);

    // two valid entries, entry 1 unmatched
    load_base();
    bus.counter_valid_vector = 32'd2;
    match_list = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp_r = '{16'd1, 16'd0, 16'd0, 16'd0};
    exp_i = '{16'd2, 16'd0, 16'd0, 16'd0};
    clear_log();
    start_sweep(0, p);
    wait_done("t3");
    check_timing("t3", p, 0);
    check_writes("t3");
    chk("t3_read_mask", 32'(rd_mask), 32'h3);
    chk("t3_reads", 32'(rd_count), 32'd2);

    // zero valid entries: no reads, all-zero writes
    load_base();
    bus.counter_valid_vector = 32'd0;
    exp_r = '{16'd0, 16'd0, 16'd0, 16'd0};
    exp_i = '{16'd0, 16'd0, 16'd0, 16'd0};
    clear_log();
    start_sweep(0, p);
    wait_done("t3b");
    check_writes("t3b");
    chk("t3b_reads", 32'(rd_count), 32'd0);

    // beta phase update holds the sweep for five extra cycles
    load_base();
    clear_log();
    start_sweep(5, p);
    wait_done("t4");
    check_timing("t4", p, 5);
    check_writes("t4");
    chk("t4_first_read", 32'(first_rd), 32'(p + 7));

    // negating the most negative value
    load_base();
    ram_r[0] = 16'h8000;
    ram_i[0] = 16'h0000;
    match_list = '{1'b1, 1'b0, 1'b0, 1'b0};
    phase_list = '{2'd2, 2'd0, 2'd0, 2'd0};
`ifdef AMP2_NEG_SATURATE_EN
    exp_r = '{16'h7FFF, 16'd0, 16'd0, 16'd0};
`else
    exp_r = '{16'h8000, 16'd0, 16'd0, 16'd0};
`endif
    exp_i = '{16'd0, 16'd0, 16'd0, 16'd0};
    clear_log();
    start_sweep(0, p);
    wait_done("t5");
    check_writes("t5");

    // reset at counter 2 aborts the sweep, then a clean sweep follows
    load_base();
    clear_log();
    start_sweep(0, p);
    k = 0;
    while (!(bus.rotateLeft_Q2_amp && bus.read_ram_alpha_address == 2'd2) && k < 20) begin
      tick();
      k++;
    end
    chk("t6_reached_cnt2", 32'(k < 20), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_outputs_zero("t6_after_rst");
    repeat (10) tick();
    chk("t6_no_writes", 32'(nw), 32'd0);
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    clear_log();
    start_sweep(0, p);
    wait_done("t6b");
    check_timing("t6b", p, 0);
    check_writes("t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
